// File: rtl/l2_bus_op_queue_if.sv
// Handshake bundle between the L2 controller, the bus-op queue and the system bus.
// The slave modport is the queue itself; master is the L2/bus side that drives it.
interface l2_bus_op_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic [1:0]              req_op;
  logic [ADDR_W-1:0]       req_addr;
  logic                    bus_valid;
  logic [1:0]              bus_op;
  logic [ADDR_W-1:0]       bus_addr;
  logic                    bus_ack;
  logic                    snoop_valid;
  logic [1:0]              snoop_result;
  logic                    rsp_valid;
  logic [1:0]              rsp_op;
  logic [ADDR_W-1:0]       rsp_addr;
  logic [1:0]              rsp_snoop;
  logic                    rsp_timeout;
  logic [$clog2(DEPTH):0]  occupancy;
  logic [15:0]             ops_done;

  modport master (
    output req_valid, req_op, req_addr, bus_ack, snoop_valid, snoop_result,
    input  req_ready, bus_valid, bus_op, bus_addr, rsp_valid, rsp_op, rsp_addr,
           rsp_snoop, rsp_timeout, occupancy, ops_done
  );

  modport slave (
    input  req_valid, req_op, req_addr, bus_ack, snoop_valid, snoop_result,
    output req_ready, bus_valid, bus_op, bus_addr, rsp_valid, rsp_op, rsp_addr,
           rsp_snoop, rsp_timeout, occupancy, ops_done
  );
endinterface

// File: rtl/l2_bus_op_queue.sv
// L2 bus-operation queue: FIFO of miss/evict/RFO ops issued one at a time on the
// system bus, with snoop collection (or timeout) and a single completion per op.
module l2_bus_op_queue #(
  parameter int ADDR_W        = 32,
  parameter int OFFSET_SIZE   = 6,
  parameter int DEPTH         = 8,
  parameter int SNOOP_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  l2_bus_op_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PW    = PTR_W + 1;
  localparam int CNT_W = $clog2(SNOOP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(SNOOP_TIMEOUT - 1);

  localparam logic [1:0] OP_READ   = 2'd0;
  localparam logic [1:0] OP_RWIM   = 2'd3;
  localparam logic [1:0] SNP_NOHIT = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_SNOOP, S_RESP} state_e;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = a;
    r[OFFSET_SIZE-1:0] = '0;
    return r;
  endfunction

  // Reserved encoding 3 is folded into NOHIT so the L2 never sees it.
  function automatic logic [1:0] map_snoop(input logic [1:0] r);
    return (r == 2'd3) ? SNP_NOHIT : r;
  endfunction

  function automatic logic needs_snoop(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_RWIM);
  endfunction

  function automatic logic is_full(input logic [PTR_W:0] w, input logic [PTR_W:0] r);
    return (w[PTR_W] != r[PTR_W]) && (w[PTR_W-1:0] == r[PTR_W-1:0]);
  endfunction

  state_e state_q, state_d;

  logic [ADDR_W+1:0]  mem_q [DEPTH];
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               req_ready_q, req_ready_d;
  logic               empty, push, pop;
  logic [1:0]         head_op;
  logic [ADDR_W-1:0]  head_addr;

  logic               bus_valid_q, bus_valid_d;
  logic [1:0]         bus_op_q, bus_op_d;
  logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [1:0]         rsp_op_q, rsp_op_d;
  logic [ADDR_W-1:0]  rsp_addr_q, rsp_addr_d;
  logic [1:0]         rsp_snoop_q, rsp_snoop_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic [15:0]        ops_done_q, ops_done_d;

  // FIFO control: ready is registered from the post-edge pointers
  always_comb begin
    empty       = (wr_ptr_q == rd_ptr_q);
    push        = bus.req_valid && req_ready_q;
    pop         = (state_q == S_IDLE) && !empty;
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    req_ready_d = !is_full(wr_ptr_d, rd_ptr_d);
    {head_op, head_addr} = mem_q[rd_ptr_q[PTR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= {bus.req_op, line_align(bus.req_addr)};
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (!empty) state_d = S_ISSUE;
      S_ISSUE:      if (bus.bus_ack) state_d = needs_snoop(bus_op_q) ? S_WAIT_SNOOP : S_RESP;
      S_WAIT_SNOOP: if (bus.snoop_valid || (cnt_q == TO_LAST)) state_d = S_RESP;
      S_RESP:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // FSM outputs: next values of the registered bus/response signals
  always_comb begin
    bus_valid_d   = bus_valid_q;
    bus_op_d      = bus_op_q;
    bus_addr_d    = bus_addr_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_op_d      = rsp_op_q;
    rsp_addr_d    = rsp_addr_q;
    rsp_snoop_d   = rsp_snoop_q;
    rsp_timeout_d = rsp_timeout_q;
    ops_done_d    = ops_done_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          bus_valid_d = 1'b1;
          bus_op_d    = head_op;
          bus_addr_d  = head_addr;
        end
      end
      S_ISSUE: begin
        if (bus.bus_ack) begin
          bus_valid_d = 1'b0;
          cnt_d       = '0;
          if (!needs_snoop(bus_op_q)) begin
            rsp_valid_d   = 1'b1;
            rsp_op_d      = bus_op_q;
            rsp_addr_d    = bus_addr_q;
            rsp_snoop_d   = SNP_NOHIT;
            rsp_timeout_d = 1'b0;
            ops_done_d    = ops_done_q + 16'd1;
          end
        end
      end
      S_WAIT_SNOOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A snoop arriving on the expiry cycle takes priority over the timeout.
        if (bus.snoop_valid || (cnt_q == TO_LAST)) begin
          rsp_valid_d   = 1'b1;
          rsp_op_d      = bus_op_q;
          rsp_addr_d    = bus_addr_q;
          rsp_snoop_d   = bus.snoop_valid ? map_snoop(bus.snoop_result) : SNP_NOHIT;
          rsp_timeout_d = !bus.snoop_valid;
          ops_done_d    = ops_done_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      req_ready_q   <= 1'b1;
      bus_valid_q   <= 1'b0;
      bus_op_q      <= '0;
      bus_addr_q    <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_op_q      <= '0;
      rsp_addr_q    <= '0;
      rsp_snoop_q   <= SNP_NOHIT;
      rsp_timeout_q <= 1'b0;
      ops_done_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      req_ready_q   <= req_ready_d;
      bus_valid_q   <= bus_valid_d;
      bus_op_q      <= bus_op_d;
      bus_addr_q    <= bus_addr_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_op_q      <= rsp_op_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_snoop_q   <= rsp_snoop_d;
      rsp_timeout_q <= rsp_timeout_d;
      ops_done_q    <= ops_done_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.bus_valid   = bus_valid_q;
  assign bus.bus_op      = bus_op_q;
  assign bus.bus_addr    = bus_addr_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_op      = rsp_op_q;
  assign bus.rsp_addr    = rsp_addr_q;
  assign bus.rsp_snoop   = rsp_snoop_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.occupancy   = wr_ptr_q - rd_ptr_q;
  assign bus.ops_done    = ops_done_q;

endmodule

// File: tb/tb_l2_bus_op_queue.sv
// Self-checking bench for l2_bus_op_queue: directed vector table, corner-case
// sequences, and a randomized run against a transaction-level reference model.
module tb_l2_bus_op_queue;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 8;
  localparam int TO     = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_bus_op_queue_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bif ();

  l2_bus_op_queue #(.ADDR_W(ADDR_W), .OFFSET_SIZE(6), .DEPTH(DEPTH), .SNOOP_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int ops_exp = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    int          ack_dly;
    int          snp_at;
    logic [1:0]  snp_res;
    logic [31:0] exp_addr;
    logic [1:0]  exp_snp;
    logic        exp_to;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
  } ent_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & ~((32'h1 << 6) - 32'h1);
  endfunction

  function automatic bit snooped(input logic [1:0] op);
    return (op == 2'd0) || (op == 2'd3);
  endfunction

  task automatic idle_inputs();
    bif.req_valid = 1'b0; bif.req_op = 2'd0; bif.req_addr = '0;
    bif.bus_ack = 1'b0; bif.snoop_valid = 1'b0; bif.snoop_result = 2'd0;
  endtask

  task automatic wait_bus(output bit got);
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      step();
      got = bif.bus_valid;
    end
  endtask

  task automatic push_wait(input logic [1:0] op, input logic [31:0] a, output bit acc);
    acc = 1'b0;
    bif.req_valid = 1'b1; bif.req_op = op; bif.req_addr = a;
    for (int k = 0; k < 6 && !acc; k++) begin
      acc = bif.req_ready;
      step();
    end
    bif.req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit got;
    int lat;
    bif.req_valid = 1'b1; bif.req_op = v.op; bif.req_addr = v.addr;
    step();
    bif.req_valid = 1'b0;
    chk($sformatf("v%0d_no_early_pop", idx), bif.bus_valid, 0);
    wait_bus(got);
    chk($sformatf("v%0d_bus_valid", idx), got, 1);
    chk($sformatf("v%0d_bus_op", idx), bif.bus_op, v.op);
    chk($sformatf("v%0d_bus_addr", idx), bif.bus_addr, v.exp_addr);
    repeat (v.ack_dly) step();
    chk($sformatf("v%0d_bus_hold", idx), bif.bus_valid, 1);
    bif.bus_ack = 1'b1;
    step();
    bif.bus_ack = 1'b0;
    chk($sformatf("v%0d_bus_drop", idx), bif.bus_valid, 0);
    lat = 0;
    got = bif.rsp_valid;
    while (!got && lat < 40) begin
      lat++;
      bif.snoop_valid = (lat == v.snp_at);
      bif.snoop_result = v.snp_res;
      step();
      bif.snoop_valid = 1'b0;
      got = bif.rsp_valid;
    end
    ops_exp++;
    chk($sformatf("v%0d_rsp_valid", idx), got, 1);
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_rsp_op", idx), bif.rsp_op, v.op);
    chk($sformatf("v%0d_rsp_addr", idx), bif.rsp_addr, v.exp_addr);
    chk($sformatf("v%0d_rsp_snoop", idx), bif.rsp_snoop, v.exp_snp);
    chk($sformatf("v%0d_rsp_timeout", idx), bif.rsp_timeout, v.exp_to);
    chk($sformatf("v%0d_ops_done", idx), bif.ops_done, ops_exp);
    step();
    chk($sformatf("v%0d_rsp_pulse", idx), bif.rsp_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   got, acc;
    int   lat, pulses, ndone;
    logic [31:0] fa[10];

    vecs[0] = '{2'd0, 32'h0000_1A7F, 2, 3,  2'd1, 32'h0000_1A40, 2'd1, 1'b0, 3};
    vecs[1] = '{2'd1, 32'h8000_0004, 0, 0,  2'd0, 32'h8000_0000, 2'd2, 1'b0, 0};
    vecs[2] = '{2'd3, 32'h1234_5678, 1, 0,  2'd0, 32'h1234_5640, 2'd2, 1'b1, TO};
    vecs[3] = '{2'd3, 32'hFFFF_FFFF, 0, TO, 2'd0, 32'hFFFF_FFC0, 2'd0, 1'b0, TO};
    vecs[4] = '{2'd0, 32'hDEAD_BEEF, 0, 1,  2'd3, 32'hDEAD_BEC0, 2'd2, 1'b0, 1};
    vecs[5] = '{2'd2, 32'h0000_0040, 3, 0,  2'd0, 32'h0000_0040, 2'd2, 1'b0, 0};
    vecs[6] = '{2'd0, 32'h0000_003F, 0, TO+1, 2'd1, 32'h0000_0000, 2'd2, 1'b1, TO};

    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_req_ready", bif.req_ready, 1);
    chk("rst_bus_valid", bif.bus_valid, 0);
    chk("rst_bus_op", bif.bus_op, 0);
    chk("rst_bus_addr", bif.bus_addr, 0);
    chk("rst_rsp_valid", bif.rsp_valid, 0);
    chk("rst_rsp_op", bif.rsp_op, 0);
    chk("rst_rsp_addr", bif.rsp_addr, 0);
    chk("rst_rsp_snoop", bif.rsp_snoop, 2);
    chk("rst_rsp_timeout", bif.rsp_timeout, 0);
    chk("rst_occupancy", bif.occupancy, 0);
    chk("rst_ops_done", bif.ops_done, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // WRITE: snoop pulses in ISSUE and on the ack cycle must be ignored
    push_wait(2'd1, 32'h8000_0004, acc);
    wait_bus(got);
    chk("wr_bus_valid", got, 1);
    bif.snoop_valid = 1'b1; bif.snoop_result = 2'd1;
    step();
    bif.bus_ack = 1'b1; bif.snoop_result = 2'd0;
    step();
    bif.bus_ack = 1'b0; bif.snoop_valid = 1'b0;
    ops_exp++;
    chk("wr_rsp_valid", bif.rsp_valid, 1);
    chk("wr_rsp_snoop", bif.rsp_snoop, 2);
    chk("wr_rsp_timeout", bif.rsp_timeout, 0);
    step();

    // READ: snoop on the ack cycle is ignored, so the op times out
    push_wait(2'd0, 32'h0000_0040, acc);
    wait_bus(got);
    bif.bus_ack = 1'b1; bif.snoop_valid = 1'b1; bif.snoop_result = 2'd1;
    step();
    bif.bus_ack = 1'b0; bif.snoop_valid = 1'b0;
    lat = 0; got = bif.rsp_valid;
    while (!got && lat < 40) begin lat++; step(); got = bif.rsp_valid; end
    ops_exp++;
    chk("ackcyc_latency", lat, TO);
    chk("ackcyc_rsp_snoop", bif.rsp_snoop, 2);
    chk("ackcyc_rsp_timeout", bif.rsp_timeout, 1);
    chk("ackcyc_ops_done", bif.ops_done, ops_exp);
    step();

    // Full FIFO: nine accepted (one in flight), tenth held off until space frees
    for (int i = 0; i < 10; i++) fa[i] = 32'h1000_0000 + 32'(i) * 32'h40 + 32'(i);
    for (int i = 0; i < 9; i++) begin
      push_wait(2'd1, fa[i], acc);
      chk($sformatf("full_push%0d", i), acc, 1);
    end
    chk("full_occupancy", bif.occupancy, DEPTH);
    chk("full_req_ready", bif.req_ready, 0);
    chk("full_head_addr", bif.bus_addr, align(fa[0]));
    bif.req_valid = 1'b1; bif.req_op = 2'd1; bif.req_addr = fa[9];
    repeat (3) step();
    chk("full_reject_occ", bif.occupancy, DEPTH);
    chk("full_reject_ready", bif.req_ready, 0);
    bif.bus_ack = 1'b1;
    ndone = 0;
    for (int c = 0; c < 200 && ndone < 10; c++) begin
      acc = bif.req_valid && bif.req_ready;
      step();
      if (acc) bif.req_valid = 1'b0;
      if (bif.rsp_valid) begin
        chk($sformatf("drain_addr%0d", ndone), bif.rsp_addr, align(fa[ndone]));
        ndone++;
      end
    end
    bif.bus_ack = 1'b0;
    ops_exp += ndone;
    chk("drain_count", ndone, 10);
    chk("drain_ops_done", bif.ops_done, ops_exp);
    repeat (3) step();

    // Simultaneous push and pop at occupancy 3
    for (int i = 0; i < 4; i++) push_wait(2'd1, 32'h2000_0000 + 32'(i) * 32'h40, acc);
    chk("pp_occ_before", bif.occupancy, 3);
    bif.bus_ack = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin step(); got = bif.rsp_valid; end
    bif.bus_ack = 1'b0;
    chk("pp_rsp", got, 1);
    step();
    chk("pp_occ_idle", bif.occupancy, 3);
    bif.req_valid = 1'b1; bif.req_addr = 32'h2000_0100;
    step();
    bif.req_valid = 1'b0;
    chk("pp_occ_same", bif.occupancy, 3);
    chk("pp_bus_valid", bif.bus_valid, 1);
    chk("pp_bus_addr", bif.bus_addr, 32'h2000_0040);

    // Reset while in ISSUE with four entries queued
    push_wait(2'd1, 32'h2000_0140, acc);
    chk("mr_occ4", bif.occupancy, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_bus_valid", bif.bus_valid, 0);
    chk("mr_occupancy", bif.occupancy, 0);
    chk("mr_req_ready", bif.req_ready, 1);
    chk("mr_ops_done", bif.ops_done, 0);
    bif.bus_ack = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      pulses += int'(bif.rsp_valid) + int'(bif.bus_valid);
      step();
    end
    bif.bus_ack = 1'b0;
    chk("mr_no_activity", pulses, 0);

    rst = 1'b1; idle_inputs();
    step();
    rst = 1'b0;
    random_phase(4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Transaction-level reference: FIFO order, snoop window of TO edges after ack,
  // and counts derived from accepted pushes / issued ops / completions.
  task automatic random_phase(input int ncyc);
    ent_t mq[$];
    ent_t cur, pend;
    bit   inflight = 0, acked = 0, exp_rsp;
    int   since_ack = 0, rsp_cnt = 0;
    logic [1:0] exp_snp;
    logic exp_to;
    logic p_req_valid = 0, p_req_ready, p_bus_valid, p_ack = 0, p_snp = 0;
    logic [1:0] p_snp_res = 0;
    p_req_ready = bif.req_ready;
    p_bus_valid = bif.bus_valid;
    pend = '{2'd0, 32'd0};
    for (int c = 0; c < ncyc; c++) begin
      exp_rsp = 0; exp_snp = 2'd2; exp_to = 0;
      if (p_req_valid && p_req_ready) mq.push_back(pend);
      if (inflight && !acked && p_bus_valid && p_ack) begin
        acked = 1; since_ack = 0;
        if (!snooped(cur.op)) exp_rsp = 1;
      end else if (inflight && acked) begin
        since_ack++;
        if (p_snp) begin
          exp_rsp = 1; exp_snp = (p_snp_res == 2'd3) ? 2'd2 : p_snp_res;
        end else if (since_ack == TO) begin
          exp_rsp = 1; exp_to = 1;
        end
      end
      chk("rnd_rsp_valid", bif.rsp_valid, exp_rsp);
      if (exp_rsp) begin
        rsp_cnt++;
        inflight = 0;
        chk("rnd_rsp_op", bif.rsp_op, cur.op);
        chk("rnd_rsp_addr", bif.rsp_addr, cur.addr);
        chk("rnd_rsp_snoop", bif.rsp_snoop, exp_snp);
        chk("rnd_rsp_timeout", bif.rsp_timeout, exp_to);
        chk("rnd_bus_low_at_rsp", bif.bus_valid, 0);
      end else if (!inflight && bif.bus_valid) begin
        chk("rnd_issue_nonempty", mq.size() > 0, 1);
        if (mq.size() > 0) begin
          cur = mq.pop_front();
          inflight = 1; acked = 0;
          chk("rnd_issue_op", bif.bus_op, cur.op);
          chk("rnd_issue_addr", bif.bus_addr, cur.addr);
        end
      end else if (inflight && !acked) begin
        chk("rnd_bus_hold", bif.bus_valid, 1);
        chk("rnd_bus_addr_stable", bif.bus_addr, cur.addr);
      end else if (inflight && acked) begin
        chk("rnd_bus_low_wait", bif.bus_valid, 0);
      end
      chk("rnd_occupancy", bif.occupancy, mq.size());
      chk("rnd_req_ready", bif.req_ready, mq.size() < DEPTH);
      chk("rnd_ops_done", bif.ops_done, rsp_cnt[15:0]);

      bif.req_valid    = ($urandom_range(0, 99) < 50);
      bif.req_op       = 2'($urandom_range(0, 3));
      bif.req_addr     = $urandom;
      bif.bus_ack      = ($urandom_range(0, 99) < 40);
      bif.snoop_valid  = ($urandom_range(0, 99) < 12);
      bif.snoop_result = 2'($urandom_range(0, 3));
      p_req_valid = bif.req_valid;
      p_req_ready = bif.req_ready;
      p_bus_valid = bif.bus_valid;
      p_ack       = bif.bus_ack;
      p_snp       = bif.snoop_valid;
      p_snp_res   = bif.snoop_result;
      pend        = '{bif.req_op, align(bif.req_addr)};
      step();
    end
    idle_inputs();
  endtask

endmodule

// File: doc/l2_bus_op_queue.md
Name: l2_bus_op_queue

Overview:
- Downstream stage of the L2 cache controller.
- Buffers the bus operations the L2 issues on misses, evictions and RFOs (READ, WRITE, INVALIDATE, RWIM) in a FIFO.
- Drives them one at a time onto the system bus with a valid/ack handshake and collects the snoop result from the other caches.
- Returns one completion per operation to the L2, carrying the snoop result (HIT/HITM/NOHIT) that the L2 feeds into its MESI update.

Parameters:
- ADDR_W, 32, address width.
- OFFSET_SIZE, 6, line-offset bits; these bits are zeroed on every issued address.
- DEPTH, 8, FIFO entries; must be a power of 2 and at least 2.
- SNOOP_TIMEOUT, 15, number of cycles to wait for a snoop response before defaulting to NOHIT.

Ports:
- clk  in  1  single clock; all logic is sampled on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  L2 presents a bus operation.
- req_ready  out  1  queue can accept an operation.
- req_op  in  2  operation code: 0 READ, 1 WRITE, 2 INVALIDATE, 3 RWIM.
- req_addr  in  ADDR_W  byte address of the operation.
- bus_valid  out  1  operation is driven on the bus.
- bus_op  out  2  operation code of the driven operation.
- bus_addr  out  ADDR_W  line-aligned address of the driven operation.
- bus_ack  in  1  bus accepts the driven operation.
- snoop_valid  in  1  snoop result is present.
- snoop_result  in  2  snoop response: 0 HIT, 1 HITM, 2 NOHIT, 3 reserved (treated as NOHIT).
- rsp_valid  out  1  one-cycle completion pulse to the L2.
- rsp_op  out  2  operation code of the completed operation.
- rsp_addr  out  ADDR_W  line-aligned address of the completed operation.
- rsp_snoop  out  2  final snoop result of the completed operation.
- rsp_timeout  out  1  completion was produced by the snoop timeout.
- occupancy  out  log2(DEPTH)+1  number of queued entries, excluding the one in flight.
- ops_done  out  16  count of completions; wraps at 16 bits.

Behaviour:
- Reset values: req_ready=1; bus_valid=0, bus_op=0, bus_addr=0; rsp_valid=0, rsp_op=0, rsp_addr=0, rsp_snoop=2 (NOHIT), rsp_timeout=0; occupancy=0; ops_done=0; FSM in IDLE; FIFO pointers cleared.
- Reset taken mid-operation discards the FIFO contents and the in-flight operation; bus_valid is low after that edge, and no completion is produced for discarded entries.
- Enqueue: occurs on an edge where req_valid=1 and req_ready=1.
  - The address is stored with bits [OFFSET_SIZE-1:0] forced to 0.
  - req_ready is registered and equals !full, so it is 0 when occupancy==DEPTH.
  - A pop in the same cycle does not let a push in while req_ready=0.
- Push and pop on the same edge: both take effect, and occupancy is unchanged.
- Pointer wrap-around: pointers are log2(DEPTH) bits with an extra wrap bit; full and empty are distinguished by the wrap bit.
- FSM IDLE:
  - If the FIFO is non-empty, pop the head into bus_op/bus_addr, set bus_valid=1, and go to ISSUE.
  - An entry written at edge k is popped no earlier than edge k+1, so bus_valid is high after edge k+1.
- FSM ISSUE:
  - Hold bus_valid, bus_op and bus_addr stable until bus_ack=1.
  - On the ack edge: bus_valid=0, clear the timeout counter.
  - READ or RWIM: go to WAIT_SNOOP.
  - WRITE or INVALIDATE: go to RESP with rsp_snoop=NOHIT.
- FSM WAIT_SNOOP:
  - The counter increments every cycle.
  - If snoop_valid=1, latch snoop_result (3 becomes 2) and go to RESP with rsp_timeout=0.
  - Otherwise, when the counter reaches SNOOP_TIMEOUT-1, go to RESP with rsp_snoop=NOHIT and rsp_timeout=1.
  - If snoop_valid arrives on the expiry cycle, the snoop wins.
- FSM RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_op and rsp_addr equal to the issued values.
  - ops_done increments on the same edge.
  - Return to IDLE.
- snoop_valid is ignored outside WAIT_SNOOP, including in the ack cycle.
- bus_ack is ignored outside ISSUE.
- Minimum time per operation: WRITE/INVALIDATE with immediate ack take 3 cycles, IDLE through RESP.
- Back-to-back operations: bus_valid for the next entry rises no earlier than the cycle after rsp_valid.
- Ordering: strict FIFO order; exactly one operation is in flight at any time.

Test Plan:
- READ and snoop: reset, push READ 0x0000_1A7F; ack 2 cycles after bus_valid; snoop_valid with result 1 (HITM) 3 cycles later -> bus_addr=0x0000_1A40, rsp_valid once, rsp_snoop=1, rsp_timeout=0, ops_done=1.
- WRITE: push WRITE 0x8000_0004 with bus_ack tied high -> completion 3 cycles after pop, rsp_snoop=2, no dependence on snoop_valid; a snoop_valid pulse during ISSUE is ignored.
- RWIM timeout: push RWIM, ack, never assert snoop_valid -> rsp_valid exactly SNOOP_TIMEOUT cycles after the ack edge, rsp_snoop=2, rsp_timeout=1. Repeat with snoop_valid=1 (HIT) on the expiry cycle -> rsp_snoop=0, rsp_timeout=0.
- Full FIFO: hold bus_ack=0, push DEPTH+1 entries -> occupancy rises to DEPTH, req_ready=0; the 10th push is not accepted and must be retried. Then release bus_ack -> entries complete in order with addresses matching the push sequence; wrap verified over 3×DEPTH pushes.
- Simultaneous push/pop: with occupancy=3, push on the same edge the FSM pops -> occupancy stays 3.
- Reset mid-operation: assert rst while in ISSUE with 4 entries queued -> the next cycle shows bus_valid=0, occupancy=0, req_ready=1, ops_done=0, and no rsp_valid pulse.
